// File: rtl/seg7_pkg.sv
// Shared segment constants and nibble-to-pattern decode for the seven-segment scan driver.
// All patterns are active-low in {a,b,c,d,e,f,g} order.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Map one nibble to its segment pattern; 10..15 become a dash unless hex_en is set.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] pat;
    case (nibble)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = hex_en ? SEG_A : SEG_DASH;
      4'hB:    pat = hex_en ? SEG_B : SEG_DASH;
      4'hC:    pat = hex_en ? SEG_C : SEG_DASH;
      4'hD:    pat = hex_en ? SEG_D : SEG_DASH;
      4'hE:    pat = hex_en ? SEG_E : SEG_DASH;
      4'hF:    pat = hex_en ? SEG_F : SEG_DASH;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational single-digit decoder with a blanking override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       hex_en,
  output logic [6:0] seg
);

  // Blanking wins over the decoded glyph.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = nibble_to_seg(nibble, hex_en);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadow register, prescaled
// digit scan with a guard cycle per slot, leading-zero blanking and registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int HEX_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int   PCNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic HEX_BIT = (HEX_EN != 0);

  logic [PCNT_W-1:0]   pcnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;

  logic                pcnt_wrap;
  logic [DIGITS-1:0]   zero_above;
  logic                zero_run;
  logic [3:0]          cur_nibble;
  logic                cur_blank;
  logic                cur_dp;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_next;

  assign pcnt_wrap = (pcnt == PCNT_W'(CLK_DIV - 1));

  // Prescaler: counts clocks within a digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt_wrap) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Slot index: advances at the end of each slot, wrapping after the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (pcnt_wrap) begin
      if (idx == IDX_W'(DIGITS - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end else begin
      idx <= idx;
    end
  end

  // Shadow register: captured on every load strobe, last strobe wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blz   <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blz   <= blank_lz;
    end else begin
      sh_value <= sh_value;
      sh_dp    <= sh_dp;
      sh_blz   <= sh_blz;
    end
  end

  // zero_above[i] is set when every shadow nibble from the top digit down to i is zero.
  always_comb begin
    zero_above = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (sh_value[4*i +: 4] == 4'h0);
      zero_above[i] = zero_run;
    end
  end

  assign cur_nibble = sh_value[4*int'(idx) +: 4];
  assign cur_blank  = sh_blz & (idx != IDX_W'(0)) & zero_above[idx];
  assign cur_dp     = sh_dp[idx];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .hex_en (HEX_BIT),
    .seg    (dec_seg)
  );

  // Next pin values: dark guard cycle at slot start, otherwise light the current digit.
  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    an_next  = '1;
    if (pcnt != PCNT_W'(0)) begin
      seg_next = dec_seg;
      dp_next  = ~cur_dp;
      for (int i = 0; i < DIGITS; i++) begin
        an_next[i] = (idx != IDX_W'(i));
      end
    end else begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
      an_next  = '1;
    end
  end

  // Output register for glitch-free pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4; one instance
// in decimal mode and one in hex mode share the same stimulus.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic [6:0]  seg_d, seg_h;
  logic        dp_d, dp_h;
  logic [3:0]  an_d, an_h;

  int checks;
  int errors;
  int n;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(0)) dut_dec (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .seg(seg_d), .dp(dp_d), .an(an_d)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .load(load), .seg(seg_h), .dp(dp_h), .an(an_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n counts rising edges since reset release; sampling happens at the following falling edge.
  function automatic bit is_guard(input int k);
    return ((k - 1) % 4) == 0;
  endfunction

  function automatic int slot_of(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (is_guard(k)) return 4'b1111;
    else return ~(one << slot_of(k));
  endfunction

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  // Reset, then load during the first edge after release; returns sampled after edge 1.
  task automatic reset_and_load(input logic [15:0] v, input logic [3:0] d, input logic blz);
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    value = v; dp_in = d; blank_lz = blz;
    @(negedge clk);
    rst = 1'b0; load = 1'b1; n = 0;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0;
    #1;
    checks++;
    if (seg_d !== 7'h7F || dp_d !== 1'b1 || an_d !== 4'hF) begin
      errors++;
      $display("FAIL reset_initial seg=%b dp=%b an=%b required seg=1111111 dp=1 an=1111", seg_d, dp_d, an_d);
    end
    reset_and_load(16'h1234, 4'h0, 1'b0);
    checks++;
    if (an_d !== 4'b1111 || seg_d !== 7'h7F) begin
      errors++;
      $display("FAIL reset_edge1 an=%b seg=%b required an=1111 seg=1111111", an_d, seg_d);
    end
    step();
    checks++;
    if (an_d !== 4'b1110 || seg_d !== 7'b1001100) begin
      errors++;
      $display("FAIL reset_edge2 an=%b seg=%b required an=1110 seg=1001100", an_d, seg_d);
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (seg_d !== 7'h7F || dp_d !== 1'b1 || an_d !== 4'hF) begin
      errors++;
      $display("FAIL reset_async seg=%b dp=%b an=%b required seg=1111111 dp=1 an=1111", seg_d, dp_d, an_d);
    end
    @(negedge clk);
    checks++;
    if (seg_d !== 7'h7F || an_d !== 4'hF) begin
      errors++;
      $display("FAIL reset_hold seg=%b an=%b required seg=1111111 an=1111", seg_d, an_d);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] tbl [4];
    logic [6:0] es;
    tbl[0] = 7'b1001100; tbl[1] = 7'b0000110; tbl[2] = 7'b0010010; tbl[3] = 7'b1001111;
    reset_and_load(16'h1234, 4'h0, 1'b0);
    repeat (17) begin
      step();
      es = is_guard(n) ? 7'h7F : tbl[slot_of(n)];
      checks++;
      if (an_d !== exp_an(n) || seg_d !== es || dp_d !== 1'b1) begin
        errors++;
        $display("FAIL scan n=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=1", n, an_d, seg_d, dp_d, exp_an(n), es);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] tbl [4];
    logic [6:0] es;
    tbl[0] = 7'b0000001; tbl[1] = 7'b0100100; tbl[2] = 7'h7F; tbl[3] = 7'h7F;
    reset_and_load(16'h0050, 4'h0, 1'b1);
    repeat (16) begin
      step();
      es = is_guard(n) ? 7'h7F : tbl[slot_of(n)];
      checks++;
      if (an_d !== exp_an(n) || seg_d !== es) begin
        errors++;
        $display("FAIL lz_0050 n=%0d an=%b seg=%b required an=%b seg=%b", n, an_d, seg_d, exp_an(n), es);
      end
    end
    tbl[1] = 7'h7F;
    reset_and_load(16'h0000, 4'h0, 1'b1);
    repeat (16) begin
      step();
      es = is_guard(n) ? 7'h7F : tbl[slot_of(n)];
      checks++;
      if (an_d !== exp_an(n) || seg_d !== es) begin
        errors++;
        $display("FAIL lz_zero n=%0d an=%b seg=%b required an=%b seg=%b", n, an_d, seg_d, exp_an(n), es);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] tbl [4];
    logic [6:0] eh;
    logic [6:0] ed;
    tbl[0] = 7'b0111000; tbl[1] = 7'b0110001; tbl[2] = 7'b1100000; tbl[3] = 7'b0001000;
    reset_and_load(16'hABCF, 4'h0, 1'b0);
    repeat (16) begin
      step();
      eh = is_guard(n) ? 7'h7F : tbl[slot_of(n)];
      ed = is_guard(n) ? 7'h7F : 7'b1111110;
      checks++;
      if (seg_h !== eh || an_h !== exp_an(n) || seg_d !== ed) begin
        errors++;
        $display("FAIL hex n=%0d seg_hex=%b seg_dec=%b an=%b required seg_hex=%b seg_dec=%b an=%b",
                 n, seg_h, seg_d, an_h, eh, ed, exp_an(n));
      end
    end
  endtask

  task automatic test_dp();
    logic edp;
    reset_and_load(16'h1234, 4'b0100, 1'b0);
    repeat (16) begin
      step();
      edp = (!is_guard(n) && slot_of(n) == 2) ? 1'b0 : 1'b1;
      checks++;
      if (dp_d !== edp || an_d !== exp_an(n)) begin
        errors++;
        $display("FAIL dp n=%0d dp=%b an=%b required dp=%b an=%b", n, dp_d, an_d, edp, exp_an(n));
      end
    end
  endtask

  task automatic test_load_mid();
    reset_and_load(16'h1234, 4'h0, 1'b0);
    while (n < 6) step();
    value = 16'h8888; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (seg_d !== 7'b0000110 || an_d !== 4'b1101) begin
      errors++;
      $display("FAIL load_mid_capture seg=%b an=%b required seg=0000110 an=1101", seg_d, an_d);
    end
    step();
    checks++;
    if (seg_d !== 7'b0000000 || an_d !== 4'b1101) begin
      errors++;
      $display("FAIL load_mid_pins seg=%b an=%b required seg=0000000 an=1101", seg_d, an_d);
    end
    while (n < 18) begin
      step();
      checks++;
      if (an_d !== exp_an(n) || seg_d !== (is_guard(n) ? 7'h7F : 7'b0000000)) begin
        errors++;
        $display("FAIL load_mid_period n=%0d an=%b seg=%b required an=%b", n, an_d, seg_d, exp_an(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_and_load(16'h1234, 4'h0, 1'b0);
    value = 16'h9999; load = 1'b1;
    step();
    value = 16'h0007;
    step();
    load = 1'b0; value = 16'h5555;
    while (n < 6) step();
    checks++;
    if (seg_d !== 7'b0000001 || an_d !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_digit1 seg=%b an=%b required seg=0000001 an=1101", seg_d, an_d);
    end
    while (n < 18) step();
    checks++;
    if (seg_d !== 7'b0001111 || an_d !== 4'b1110) begin
      errors++;
      $display("FAIL b2b_digit0 seg=%b an=%b required seg=0001111 an=1110", seg_d, an_d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n = 0;
    test_reset();
    test_scan();
    test_lz();
    test_hex();
    test_dp();
    test_load_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
